wb_write_arbiter: RTL
=====================

Name: wb_write_arbiter

Overview:
- Sole driver of the register file write port (regWrite/writeReg/writeData); sits at the end of WB.
- Merges in-order pipeline writebacks with out-of-order results from long-latency units (mul/div) through a small FIFO.
- Exports a busy mask of queued destinations to the ID hazard unit.
- Raises a stall request when queued results are starved.

Parameters:
DEPTH, 2, late-result FIFO entries; power of two, >=2
STARVE_LIMIT, 4, consecutive blocked-drain cycles before stallReq asserts; >=1

Ports:
clk  input  1  clock, all state on posedge
resetn  input  1  asynchronous active-low reset
wbValid  input  1  pipeline WB slot holds an instruction
wbRegWrite  input  1  that instruction writes rd
wbRd  input  5  pipeline destination register
wbData  input  32  pipeline result
lateValid  input  1  late unit offers a result
lateReady  output  1  arbiter accepts late result this cycle
lateRd  input  5  late destination register
lateData  input  32  late result
regWrite  output  1  register file write enable (registered)
writeReg  output  5  register file write index (registered)
writeData  output  32  register file write data (registered)
busyMask  output  32  bit i=1 while any FIFO entry targets xi
stallReq  output  1  request upstream to hold WB slot empty

Behaviour:
- Reset (async, resetn=0):
  - regWrite=0, writeReg=0, writeData=0.
  - FIFO empty, starve counter=0.
  - lateReady=1, busyMask=0, stallReq=0.
  - Reset mid-operation discards queued entries.
- Pipeline write request: pw = wbValid & wbRegWrite & (wbRd!=0).
- Late accept:
  - acc = lateValid & lateReady.
  - lateReady = !full; there is no same-cycle pass-through when full.
  - An accepted result with lateRd==0 is consumed and dropped, not enqueued.
- Slot selection each cycle (registered outputs update at the next posedge, 1-cycle latency):
  - stallReq=1 and FIFO non-empty: drain FIFO head. The pipeline request is ignored; the upstream contract is to hold wbValid=0.
  - else if pw: write {wbRd, wbData}.
  - else if FIFO non-empty: drain head.
  - else: regWrite=0. writeReg and writeData hold their previous values.
- An accepted late result always enqueues first. Earliest possible write port appearance is 2 posedges after acceptance.
- Simultaneous enqueue and dequeue in the same cycle is legal when not full. The count is unchanged and the pointers wrap modulo DEPTH.
- FIFO order is strict FIFO.
- busyMask:
  - Combinational OR over valid entries.
  - Clears for an entry on the posedge that dequeues it (same edge regWrite rises for it).
- WAW ordering between pipeline and queued writes to the same rd is the hazard unit's responsibility, via busyMask. The arbiter does not reorder.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head is blocked by pw (saturates at STARVE_LIMIT).
  - Clears on any drain or when the FIFO is empty.
  - stallReq = (counter==STARVE_LIMIT) & non-empty; decoded from registered state.
- Writes to x0 never produce regWrite=1.

Test Plan:
- Reset: assert resetn=0 mid-stream with 2 queued entries -> next cycle all outputs 0, busyMask=0, lateReady=1; the entries are never written.
- Pipeline only: wbValid=1, wbRegWrite=1, wbRd=5, wbData=0xDEADBEEF -> next posedge regWrite=1, writeReg=5, writeData=0xDEADBEEF. Same with wbRd=0 -> regWrite=0.
- Late drain into idle slot: lateValid=1, lateRd=7, lateData=0x12345678, pipeline idle -> busyMask[7]=1 after the 1st edge; at the 2nd edge regWrite=1, writeReg=7 and busyMask[7]=0.
- Full FIFO: DEPTH=2, enqueue rd 3 then rd 4 while pw is held every cycle -> lateReady=0 and a 3rd offer stalls. Once drained, the writes occur in order 3 then 4.
- Starvation: queue rd 9, hold pw on rd 1 for 4 cycles -> stallReq=1 in cycle 5. With wbValid forced 1, the write port still shows writeReg=9, and stallReq drops after the drain.
- Late x0 plus simultaneous traffic: lateRd=0 accepted alongside pw to rd 2 -> only rd 2 is written; FIFO stays empty, busyMask=0.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Sole driver of the register-file write port. Each cycle it picks one of
//   two sources and registers it onto the port: the in-order pipeline
//   writeback, or the head of a small FIFO that holds out-of-order results
//   from long-latency units (mul/div). The pipeline normally wins. A starve
//   counter forces the queued results through once they have been blocked
//   for too long.
//
// Ports
//   clk, resetn                 clock (posedge), async active-low reset
//   wbValid/wbRegWrite/wbRd/wbData   pipeline writeback request
//   lateValid/lateReady/lateRd/lateData  late-result handshake
//   regWrite/writeReg/writeData  registered register-file write port
//   busyMask                    destinations currently queued in the FIFO
//   stallReq                    asks upstream to keep the WB slot empty
module wb_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wbValid,
  input  logic        wbRegWrite,
  input  logic [4:0]  wbRd,
  input  logic [31:0] wbData,
  input  logic        lateValid,
  output logic        lateReady,
  input  logic [4:0]  lateRd,
  input  logic [31:0] lateData,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic [31:0] busyMask,
  output logic        stallReq
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       rdQ   [DEPTH];
  logic [31:0]      dataQ [DEPTH];
  logic [DEPTH-1:0] validQ;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    starveCnt;

  logic full;
  logic empty;
  logic pw;
  logic acc;
  logic enq;
  logic deq;

  // Per-entry valid bits stand in for an occupancy counter: the slot under
  // the write pointer being occupied means full, the slot under the read
  // pointer being free means empty.
  assign full      = validQ[wrPtr];
  assign empty     = !validQ[rdPtr];
  assign lateReady = !full;
  assign pw        = wbValid & wbRegWrite & (wbRd != 5'd0);
  assign acc       = lateValid & lateReady;
  // Accepted x0 results are consumed here and never reach the FIFO.
  assign enq       = acc & (lateRd != 5'd0);
  assign stallReq  = (starveCnt == CW'(STARVE_LIMIT)) & !empty;
  assign deq       = !empty & (stallReq | !pw);

  always_comb begin
    busyMask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (validQ[i]) busyMask[rdQ[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      rdQ[wrPtr]   <= lateRd;
      dataQ[wrPtr] <= lateData;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      validQ    <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      starveCnt <= '0;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      // enq and deq never target the same slot: enq needs a free slot at
      // wrPtr, deq needs an occupied slot at rdPtr.
      if (enq) begin
        validQ[wrPtr] <= 1'b1;
        wrPtr         <= wrPtr + 1'b1;
      end
      if (deq) begin
        validQ[rdPtr] <= 1'b0;
        rdPtr         <= rdPtr + 1'b1;
      end

      // Not draining while non-empty can only mean the head lost to pw.
      if (empty || deq) begin
        starveCnt <= '0;
      end else if (starveCnt != CW'(STARVE_LIMIT)) begin
        starveCnt <= starveCnt + 1'b1;
      end

      if (deq) begin
        regWrite  <= 1'b1;
        writeReg  <= rdQ[rdPtr];
        writeData <= dataQ[rdPtr];
      end else if (pw) begin
        regWrite  <= 1'b1;
        writeReg  <= wbRd;
        writeData <= wbData;
      end else begin
        regWrite  <= 1'b0;
      end
    end
  end

endmodule
